// File: rtl/pio_seq_pkg.sv
// Shared definitions for the PIO pattern sequencer: FSM states, slave
// register map and CONTROL/STATUS bit positions.
package pio_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DWELL = 2'd2
  } seq_state_t;

  // Slave register addresses
  localparam logic [1:0] ADDR_PATTERN = 2'd0;
  localparam logic [1:0] ADDR_DWELL   = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  // CONTROL bit positions
  localparam int unsigned CTRL_RUN    = 0;
  localparam int unsigned CTRL_FLUSH  = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;

  // STATUS bit positions
  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_EMPTY     = 1;
  localparam int unsigned STAT_FULL      = 2;
  localparam int unsigned STAT_OVERFLOW  = 3;
  localparam int unsigned STAT_LEVEL_LSB = 8;

endpackage

// File: rtl/pio_seq_fifo.sv
// Synchronous FIFO holding {pattern, dwell} entries. Flush dominates push
// and pop; push is refused when full, pop is refused when empty.
module pio_seq_fifo #(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == LW'(DEPTH));
  assign empty   = (cnt == '0);
  assign level   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  // Pointer and occupancy tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + LW'(1);
        2'b01:   cnt <= cnt - LW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/pio_pattern_sequencer.sv
// CPU-programmed pattern sequencer: queues {pattern, dwell} pairs and plays
// them out as single-cycle writes to a PIO slave, spaced by the dwell time.
module pio_pattern_sequencer
  import pio_seq_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned DWELL_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata,
  output logic        irq
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = 24 + DWELL_W;

  seq_state_t         state_q;
  logic [23:0]        hold_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] cnt_q;
  logic               run_q;
  logic               irq_en_q;
  logic               flush_q;
  logic               ovf_q;
  logic               irq_q;
  logic               pio_cs_q;
  logic               pio_wr_n_q;
  logic [31:0]        pio_wd_q;

  logic               wr_en;
  logic               push_req;
  logic               pop;
  logic [EW-1:0]      head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [LW-1:0]      fifo_level;
  logic [6:0]         level7;
  logic               unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign push_req     = wr_en & (address == ADDR_DWELL);
  assign pop          = (state_q == ST_IDLE) & run_q & ~fifo_empty & ~flush_q;
  assign level7       = 7'(fifo_level);
  assign unused_wdata = ^writedata;

  assign pio_address    = 2'b00;
  assign pio_chipselect = pio_cs_q;
  assign pio_write_n    = pio_wr_n_q;
  assign pio_writedata  = pio_wd_q;
  assign irq            = irq_q;

  pio_seq_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_req),
    .pop     (pop),
    .flush   (flush_q),
    .wdata   ({hold_q, writedata[DWELL_W-1:0]}),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Slave registers, flush pulse, overflow flag and interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q   <= '0;
      dwell_q  <= '0;
      run_q    <= 1'b0;
      irq_en_q <= 1'b0;
      flush_q  <= 1'b0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      flush_q <= 1'b0;
      if (wr_en) begin
        case (address)
          ADDR_PATTERN: hold_q <= writedata[23:0];
          ADDR_DWELL:   dwell_q <= writedata[DWELL_W-1:0];
          ADDR_CONTROL: begin
            run_q    <= writedata[CTRL_RUN];
            irq_en_q <= writedata[CTRL_IRQ_EN];
            flush_q  <= writedata[CTRL_FLUSH];
          end
          default: if (writedata[STAT_OVERFLOW]) ovf_q <= 1'b0;
        endcase
      end
      // A push landing on the flush cycle is dropped without flagging overflow
      if (push_req & fifo_full & ~flush_q) ovf_q <= 1'b1;
      irq_q <= irq_en_q & (ovf_q | (run_q & fifo_empty & (state_q == ST_IDLE)));
    end
  end

  // Playback FSM with registered PIO strobe/data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pio_cs_q   <= 1'b0;
      pio_wr_n_q <= 1'b1;
      pio_wd_q   <= '0;
    end else begin
      pio_cs_q   <= 1'b0;
      pio_wr_n_q <= 1'b1;
      pio_wd_q   <= '0;
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            state_q    <= ST_WRITE;
            cnt_q      <= head[DWELL_W-1:0];
            pio_cs_q   <= 1'b1;
            pio_wr_n_q <= 1'b0;
            pio_wd_q   <= {8'h00, head[EW-1 -: 24]};
          end
        end
        ST_WRITE: begin
          // cnt_q already holds the popped dwell; zero dwell skips DWELL
          if (flush_q || cnt_q == '0) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else begin
            state_q <= ST_DWELL;
          end
        end
        ST_DWELL: begin
          cnt_q <= cnt_q - DWELL_W'(1);
          if (flush_q || cnt_q == DWELL_W'(1)) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Zero-wait read mux
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_PATTERN: readdata = {8'h00, hold_q};
      ADDR_DWELL:   readdata = 32'(dwell_q);
      ADDR_CONTROL: readdata = {29'd0, irq_en_q, 1'b0, run_q};
      default:      readdata = {17'd0, level7, 4'd0, ovf_q, fifo_full, fifo_empty,
                                (state_q != ST_IDLE)};
    endcase
  end

endmodule

// File: tb/tb_pio_pattern_sequencer.sv
// Directed self-checking bench for pio_pattern_sequencer (DEPTH=8, DWELL_W=16).
module tb_pio_pattern_sequencer;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic        irq;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          st_t[$];
  logic [31:0] st_d[$];

  pio_pattern_sequencer #(
    .DEPTH   (8),
    .DWELL_W (16)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .address        (address),
    .chipselect     (chipselect),
    .write_n        (write_n),
    .writedata      (writedata),
    .readdata       (readdata),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .irq            (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe recorder, sampled 1 time unit after the rising edge
  always @(posedge clk) begin
    #1;
    if (pio_chipselect === 1'b1 && pio_write_n === 1'b0) begin
      st_t.push_back(cyc);
      st_d.push_back(pio_writedata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the write is captured on the next rising edge
  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic push(input logic [23:0] pat, input logic [15:0] dw);
    cpu_write(2'd0, {8'h00, pat});
    cpu_write(2'd1, {16'h0000, dw});
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [31:0] rv;
    int          c0;
    int          b;
    int          busy_n;

    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = '0;
    idle(2);

    // Reset state
    chk("rst_pio_cs", {31'd0, pio_chipselect}, 32'd0);
    chk("rst_pio_wr_n", {31'd0, pio_write_n}, 32'd1);
    chk("rst_pio_wd", pio_writedata, 32'd0);
    chk("rst_pio_addr", {30'd0, pio_address}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rd(2'd3, rv);
    chk("rst_status", rv, 32'h0000_0002);
    reset_n = 1'b1;
    idle(1);

    // Single entry, dwell 3, run with irq_en
    b = st_t.size();
    push(24'hA5A5A5, 16'd3);
    cpu_write(2'd2, 32'h5);
    c0 = cyc;
    busy_n = 0;
    for (int i = 0; i < 10; i++) begin
      rd(2'd3, rv);
      if (rv[0]) busy_n++;
      idle(1);
    end
    chk("t1_strobes", 32'(st_t.size() - b), 32'd1);
    if (st_t.size() > b) begin
      chk("t1_data", st_d[b], 32'h00A5_A5A5);
      chk("t1_time", 32'(st_t[b] - c0), 32'd1);
    end
    chk("t1_busy_cycles", 32'(busy_n), 32'd4);
    chk("t1_irq", {31'd0, irq}, 32'd1);
    cpu_write(2'd2, 32'h0);

    // Three entries, dwells 0/2/5: strobes at t, t+2, t+6
    b = st_t.size();
    push(24'h111111, 16'd0);
    push(24'h222222, 16'd2);
    push(24'h333333, 16'd5);
    cpu_write(2'd2, 32'h1);
    c0 = cyc;
    idle(20);
    chk("t2_strobes", 32'(st_t.size() - b), 32'd3);
    if (st_t.size() >= b + 3) begin
      chk("t2_t0", 32'(st_t[b] - c0), 32'd1);
      chk("t2_t1", 32'(st_t[b+1] - st_t[b]), 32'd2);
      chk("t2_t2", 32'(st_t[b+2] - st_t[b]), 32'd6);
      chk("t2_d0", st_d[b], 32'h0011_1111);
      chk("t2_d1", st_d[b+1], 32'h0022_2222);
      chk("t2_d2", st_d[b+2], 32'h0033_3333);
    end
    cpu_write(2'd2, 32'h0);

    // Nine pushes into an 8-deep FIFO with run off
    for (int i = 0; i < 9; i++) push(24'(32'h100 + i), 16'(i + 1));
    rd(2'd3, rv);
    chk("t3_status_full_ovf", rv, 32'h0000_080C);
    rd(2'd0, rv);
    chk("t3_pattern_rb", rv, 32'h0000_0108);
    rd(2'd1, rv);
    chk("t3_dwell_rb", rv, 32'h0000_0009);
    idle(1);
    cpu_write(2'd3, 32'h8);
    rd(2'd3, rv);
    chk("t3_ovf_clear", rv, 32'h0000_0804);
    idle(1);
    // Flush immediately followed by a push into the still-full FIFO
    cpu_write(2'd2, 32'h6);
    cpu_write(2'd1, 32'h7);
    rd(2'd3, rv);
    chk("t3_flush_push", rv, 32'h0000_0002);
    rd(2'd2, rv);
    chk("t3_ctrl_rb", rv, 32'h0000_0004);
    idle(1);
    cpu_write(2'd2, 32'h0);

    // Flush during the first DWELL
    b = st_t.size();
    for (int i = 0; i < 4; i++) push(24'(32'hAAAA01 + i), 16'd100);
    cpu_write(2'd2, 32'h1);
    idle(5);
    cpu_write(2'd2, 32'h3);
    rd(2'd3, rv);
    chk("t4_pending_flush", rv, 32'h0000_0301);
    idle(1);
    rd(2'd3, rv);
    chk("t4_after_flush", rv, 32'h0000_0002);
    idle(30);
    chk("t4_strobes", 32'(st_t.size() - b), 32'd1);
    cpu_write(2'd2, 32'h0);

    // Clear run during the second entry's DWELL
    b = st_t.size();
    for (int i = 0; i < 4; i++) push(24'(32'hB00001 + i), 16'd4);
    cpu_write(2'd2, 32'h1);
    for (int i = 0; i < 50 && st_t.size() < b + 2; i++) idle(1);
    idle(2);
    cpu_write(2'd2, 32'h0);
    idle(30);
    chk("t5_strobes", 32'(st_t.size() - b), 32'd2);
    if (st_t.size() >= b + 2) begin
      chk("t5_d1", st_d[b+1], 32'h00B0_0002);
      chk("t5_spacing", 32'(st_t[b+1] - st_t[b]), 32'd6);
    end
    rd(2'd3, rv);
    chk("t5_status", rv, 32'h0000_0200);
    idle(1);

    // Reset asserted mid-DWELL
    cpu_write(2'd2, 32'h2);
    push(24'hC0FFEE, 16'd50);
    cpu_write(2'd2, 32'h5);
    idle(5);
    reset_n = 1'b0;
    b = st_t.size();
    #1;
    chk("t6_pio_cs", {31'd0, pio_chipselect}, 32'd0);
    chk("t6_pio_wr_n", {31'd0, pio_write_n}, 32'd1);
    chk("t6_pio_wd", pio_writedata, 32'd0);
    chk("t6_irq", {31'd0, irq}, 32'd0);
    rd(2'd3, rv);
    chk("t6_status", rv, 32'h0000_0002);
    rd(2'd2, rv);
    chk("t6_ctrl", rv, 32'h0000_0000);
    idle(2);
    reset_n = 1'b1;
    idle(20);
    chk("t6_no_strobe_released", 32'(st_t.size() - b), 32'd0);
    push(24'h123456, 16'd1);
    idle(10);
    chk("t6_no_strobe_norun", 32'(st_t.size() - b), 32'd0);
    cpu_write(2'd2, 32'h1);
    idle(10);
    chk("t6_strobes", 32'(st_t.size() - b), 32'd1);
    if (st_t.size() > b) chk("t6_data", st_d[b], 32'h0012_3456);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pio_pattern_sequencer.md
PIO_PATTERN_SEQUENCER -- requirements
Module: pio_pattern_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter DWELL_W, default 16, dwell counter width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port address, input, 2, CPU slave register select.
REQ-006 SHALL have port chipselect, input, 1, CPU slave select.
REQ-007 SHALL have port write_n, input, 1, CPU slave write strobe (active low).
REQ-008 SHALL have port writedata, input, 32, CPU slave write data.
REQ-009 SHALL have port readdata, output, 32, CPU slave read data; combinational from address, zero-wait.
REQ-010 SHALL have port pio_address, output, 2, PIO s1 address; constant 0.
REQ-011 SHALL have port pio_chipselect, output, 1, PIO s1 select.
REQ-012 SHALL have port pio_write_n, output, 1, PIO s1 write strobe (active low).
REQ-013 SHALL have port pio_writedata, output, 32, PIO s1 data; {8'b0, pattern[23:0]}.
REQ-014 SHALL have port irq, output, 1, registered level interrupt.

Function
REQ-015 SHALL decode the slave map: 0 PATTERN (W: hold reg[23:0]); 1 DWELL (W: push {hold, writedata[DWELL_W-1:0]}); 2 CONTROL (R/W: bit0 run, bit1 flush, bit2 irq_en); 3 STATUS (R: bit0 busy, bit1 empty, bit2 full, bit3 overflow, bits[14:8] level; W: writing 1 to bit3 clears overflow).
REQ-016 SHALL read back the PATTERN hold register at address 0 and the last written dwell value at address 1; CONTROL bit1 SHALL read 0.
REQ-017 SHALL treat flush as a self-clearing one-cycle pulse when CONTROL is written with bit1=1.
REQ-018 SHALL accept a push only when the FIFO is not full at the start of the cycle; a push when full is discarded and sets overflow, even if a pop occurs in the same cycle.
REQ-019 SHALL allow a simultaneous accepted push and pop, leaving level unchanged.
REQ-020 SHALL implement FSM states IDLE, WRITE, DWELL.
REQ-021 IDLE: if run=1 and FIFO not empty, SHALL pop the head entry and go to WRITE next cycle; otherwise stay.
REQ-022 WRITE: SHALL assert pio_chipselect=1 and pio_write_n=0 for exactly one cycle with the popped pattern; then go to DWELL with counter=dwell if dwell!=0, else to IDLE.
REQ-023 DWELL: SHALL decrement the counter each cycle and go to IDLE in the cycle it reaches 0 (DWELL lasts exactly dwell cycles).
REQ-024 Consecutive PIO writes SHALL therefore be spaced exactly dwell+2 cycles apart while run=1 and the FIFO stays non-empty.
REQ-025 Outside WRITE, pio_chipselect SHALL be 0, pio_write_n 1, and pio_writedata 0.
REQ-026 Clearing run mid-sequence SHALL let the current WRITE/DWELL finish, then hold in IDLE without popping.
REQ-027 Flush SHALL empty the FIFO and force the FSM to IDLE next cycle from any state; a WRITE in progress completes its single strobe; flush and push in the same cycle: flush wins, push discarded, overflow unchanged.
REQ-028 busy SHALL be 1 whenever the FSM is not in IDLE.
REQ-029 irq SHALL register irq_en & (overflow | (run & empty & state==IDLE)).

Reset
REQ-030 On reset_n low, SHALL asynchronously clear the FSM to IDLE, FIFO pointers/level, hold reg, dwell reg, CONTROL, overflow, dwell counter, and irq; pio_chipselect=0, pio_write_n=1, pio_writedata=0.
REQ-031 Reset asserted mid-DWELL or mid-WRITE SHALL abort immediately with no further PIO strobe after release until run is set.

Structure
REQ-032 SHALL place the FSM state enum, the slave register address constants, and the CONTROL/STATUS bit positions in shared package pio_seq_pkg.
REQ-033 SHALL instantiate one sub-module pio_seq_fifo: synchronous FIFO, width 24+DWELL_W, depth DEPTH, with push/pop/flush/full/empty/level.

Verification
REQ-034 Push (0xA5A5A5, dwell 3), set run -> one PIO write of 0x00A5A5A5, busy for 4 cycles, irq=1 after return to IDLE if irq_en=1.
REQ-035 Push 3 entries with dwells 0, 2, 5, run=1 -> PIO strobes at t, t+2, t+6; patterns in push order.
REQ-036 Push 9 entries with DEPTH=8, run=0 -> full=1, overflow=1, level=8; write STATUS bit3=1 -> overflow=0.
REQ-037 Run with 4 entries of dwell 100, flush during the first DWELL -> FSM in IDLE next cycle, empty=1, no further strobes.
REQ-038 Clear run during the second entry's DWELL -> that dwell completes, then no strobe, level=2 retained.
REQ-039 Assert reset_n mid-DWELL -> all outputs at reset values; after release, no strobe until run=1 and a new push.
